// File: rtl/fifo_port_arbiter.sv
// Two-producer write arbiter and single-consumer read sequencer for a 2^W-entry register-file FIFO.
// Define FIFO_ARB_RR_EN for round-robin arbitration; otherwise producer 0 has fixed priority.
module fifo_port_arbiter #(
    parameter int B = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [B-1:0] data0,
    input  logic [B-1:0] data1,
    input  logic         rd_req,
    output logic         gnt0,
    output logic         gnt1,
    output logic         wr_en,
    output logic [W-1:0] w_addr,
    output logic [B-1:0] w_data,
    output logic         rd_en,
    output logic [W-1:0] r_addr,
    output logic [W:0]   count,
    output logic         full,
    output logic         empty,
    output logic         rd_err
);

    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [W:0] DEPTH = {1'b1, {W{1'b0}}};

    state_t       state_q, state_d;
    logic         gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic         wr_en_q, wr_en_d, rd_en_q, rd_en_d, rd_err_q, rd_err_d;
    logic [W-1:0] w_addr_q, w_addr_d, r_addr_q, r_addr_d;
    logic [B-1:0] w_data_q, w_data_d;
    logic [W:0]   count_q, count_d;
    logic         armed0_q, armed0_d, armed1_q, armed1_d;
    logic         rd_pend_q, rd_pend_d;
    logic         elig0, elig1, sel1, full_c, empty_c;

    assign elig0   = req0 & armed0_q;
    assign elig1   = req1 & armed1_q;
    assign full_c  = (count_q == DEPTH);
    assign empty_c = (count_q == '0);

`ifdef FIFO_ARB_RR_EN
    logic prio_q, prio_d;

    // prio_q set means producer 1 wins the next contention
    assign sel1 = elig1 & (~elig0 | prio_q);
`else
    assign sel1 = ~elig0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        rd_err_d  = 1'b0;
        w_addr_d  = w_addr_q;
        r_addr_d  = r_addr_q;
        w_data_d  = w_data_q;
        count_d   = count_q;
        rd_pend_d = rd_pend_q;
`ifdef FIFO_ARB_RR_EN
        prio_d    = prio_q;
`endif
        case (state_q)
            IDLE: begin
                if ((elig0 | elig1) && !full_c) begin
                    wr_en_d = 1'b1;
                    if (sel1) begin
                        gnt1_d   = 1'b1;
                        w_data_d = data1;
                    end else begin
                        gnt0_d   = 1'b1;
                        w_data_d = data0;
                    end
`ifdef FIFO_ARB_RR_EN
                    prio_d = ~sel1;
`endif
                end
                // A pending read always resolves here: issued, or dropped with rd_err
                if (rd_pend_q | rd_req) begin
                    if (empty_c) rd_err_d = 1'b1;
                    else         rd_en_d  = 1'b1;
                end
                rd_pend_d = 1'b0;
                if (wr_en_d | rd_en_d) state_d = ISSUE;
            end
            ISSUE: begin
                w_addr_d  = w_addr_q + W'(wr_en_q);
                r_addr_d  = r_addr_q + W'(rd_en_q);
                count_d   = count_q + (W+1)'(wr_en_q) - (W+1)'(rd_en_q);
                rd_pend_d = rd_pend_q | rd_req;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        armed0_d = req0 ? (armed0_q & ~gnt0_d) : 1'b1;
        armed1_d = req1 ? (armed1_q & ~gnt1_d) : 1'b1;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_err_q  <= 1'b0;
            w_addr_q  <= '0;
            r_addr_q  <= '0;
            w_data_q  <= '0;
            count_q   <= '0;
            armed0_q  <= 1'b1;
            armed1_q  <= 1'b1;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            rd_err_q  <= rd_err_d;
            w_addr_q  <= w_addr_d;
            r_addr_q  <= r_addr_d;
            w_data_q  <= w_data_d;
            count_q   <= count_d;
            armed0_q  <= armed0_d;
            armed1_q  <= armed1_d;
            rd_pend_q <= rd_pend_d;
        end
    end

`ifdef FIFO_ARB_RR_EN
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) prio_q <= 1'b0;
        else          prio_q <= prio_d;
    end
`endif

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign wr_en  = wr_en_q;
    assign rd_en  = rd_en_q;
    assign rd_err = rd_err_q;
    assign w_addr = w_addr_q;
    assign r_addr = r_addr_q;
    assign w_data = w_data_q;
    assign count  = count_q;
    assign full   = full_c;
    assign empty  = empty_c;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Self-checking bench for fifo_port_arbiter: transaction-level FIFO model compared every cycle,
// plus directed scenarios with literal expectations. Honours FIFO_ARB_RR_EN like the design.
module tb_fifo_port_arbiter;

    localparam int B = 8;
    localparam int W = 2;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         n_reset = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0, rd_req = 1'b0;
    logic [B-1:0] data0 = '0, data1 = '0;
    logic         gnt0, gnt1, wr_en, rd_en, full, empty, rd_err;
    logic [W-1:0] w_addr, r_addr;
    logic [B-1:0] w_data;
    logic [W:0]   count;

    int errors = 0;
    int checks = 0;

    fifo_port_arbiter #(.B(B), .W(W)) dut (
        .clk(clk), .n_reset(n_reset),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .rd_req(rd_req),
        .gnt0(gnt0), .gnt1(gnt1), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
        .rd_en(rd_en), .r_addr(r_addr), .count(count),
        .full(full), .empty(empty), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    // Model: an occupancy counter and running write/read totals; a transaction accepted at an
    // edge shows as strobes for one cycle and lands in the totals one cycle later.
    bit       e_wr, e_rd, e_err, e_gnt0, e_gnt1;
    logic [B-1:0] e_wdata;
    int       m_count, m_writes, m_reads;
    bit       m_busy, m_pend, m_arm0, m_arm1, m_prio;

    task automatic modelReset();
        e_wr = 0; e_rd = 0; e_err = 0; e_gnt0 = 0; e_gnt1 = 0; e_wdata = '0;
        m_count = 0; m_writes = 0; m_reads = 0;
        m_busy = 0; m_pend = 0; m_arm0 = 1; m_arm1 = 1; m_prio = 0;
    endtask

    task automatic modelStep();
        int winner;
        bit want_rd;
        if (!n_reset) begin
            modelReset();
            return;
        end
        if (m_busy) begin
            if (e_wr) begin m_count++; m_writes++; end
            if (e_rd) begin m_count--; m_reads++; end
            if (rd_req) m_pend = 1;
            e_wr = 0; e_rd = 0; e_err = 0; e_gnt0 = 0; e_gnt1 = 0;
            m_busy = 0;
        end else begin
            e_wr = 0; e_rd = 0; e_err = 0; e_gnt0 = 0; e_gnt1 = 0;
            winner = -1;
            if (req0 && m_arm0 && req1 && m_arm1) begin
`ifdef FIFO_ARB_RR_EN
                winner = m_prio ? 1 : 0;
`else
                winner = 0;
`endif
            end else if (req0 && m_arm0) winner = 0;
            else if (req1 && m_arm1) winner = 1;
            if (winner >= 0 && m_count < DEPTH) begin
                e_wr = 1;
                if (winner == 0) begin e_gnt0 = 1; e_wdata = data0; m_arm0 = 0; m_prio = 1; end
                else             begin e_gnt1 = 1; e_wdata = data1; m_arm1 = 0; m_prio = 0; end
            end
            want_rd = m_pend | rd_req;
            if (want_rd) begin
                if (m_count == 0) e_err = 1;
                else              e_rd  = 1;
            end
            m_pend = 0;
            m_busy = e_wr | e_rd;
        end
        if (!req0) m_arm0 = 1;
        if (!req1) m_arm1 = 1;
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge n_reset);
            modelStep();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            checkOutput("model.wr_en",  32'(wr_en),  32'(e_wr));
            checkOutput("model.gnt0",   32'(gnt0),   32'(e_gnt0));
            checkOutput("model.gnt1",   32'(gnt1),   32'(e_gnt1));
            checkOutput("model.rd_en",  32'(rd_en),  32'(e_rd));
            checkOutput("model.rd_err", 32'(rd_err), 32'(e_err));
            checkOutput("model.w_data", 32'(w_data), 32'(e_wdata));
            checkOutput("model.w_addr", 32'(w_addr), 32'(m_writes % DEPTH));
            checkOutput("model.r_addr", 32'(r_addr), 32'(m_reads % DEPTH));
            checkOutput("model.count",  32'(count),  32'(m_count));
            checkOutput("model.full",   32'(full),   32'(m_count == DEPTH));
            checkOutput("model.empty",  32'(empty),  32'(m_count == 0));
        end
    end

    // Drive one cycle's inputs and advance to the next falling edge.
    task automatic applyStimulus(input logic r0, input logic [B-1:0] d0,
                                 input logic r1, input logic [B-1:0] d1, input logic rd);
        req0 = r0; data0 = d0; req1 = r1; data1 = d1; rd_req = rd;
        @(negedge clk);
    endtask

    task automatic applyReset();
        req0 = 0; req1 = 0; rd_req = 0;
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic writeWord(input logic [B-1:0] d);
        applyStimulus(1, d, 0, 8'h00, 0);
        applyStimulus(0, d, 0, 8'h00, 0);
    endtask

    int winners[4];
    int expected_winners[4];
    int gcount;
    int gaddr;

    initial begin
`ifdef FIFO_ARB_RR_EN
        expected_winners = '{0, 1, 0, 1};
`else
        expected_winners = '{0, 0, 0, 0};
`endif
        repeat (2) @(negedge clk);
        checkOutput("reset.count", 32'(count), 0);
        checkOutput("reset.empty", 32'(empty), 1);
        checkOutput("reset.full", 32'(full), 0);
        n_reset = 1'b1;
        @(negedge clk);

        // Single write: strobes one cycle after the request is seen
        applyStimulus(1, 8'hA5, 0, 8'h00, 0);
        checkOutput("wr1.gnt0", 32'(gnt0), 1);
        checkOutput("wr1.wr_en", 32'(wr_en), 1);
        checkOutput("wr1.w_addr", 32'(w_addr), 0);
        checkOutput("wr1.w_data", 32'(w_data), 32'hA5);
        applyStimulus(0, 8'hA5, 0, 8'h00, 0);
        checkOutput("wr1.count", 32'(count), 1);
        checkOutput("wr1.empty", 32'(empty), 0);

        // Holding req0 yields exactly one grant
        gcount = 0; gaddr = -1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 8'h5A, 0, 8'h00, 0);
            if (gnt0) begin gcount++; gaddr = int'(w_addr); end
        end
        checkOutput("hold.grants", 32'(gcount), 1);
        checkOutput("hold.w_addr", 32'(gaddr), 1);
        applyStimulus(0, 8'h5A, 0, 8'h00, 0);
        applyStimulus(1, 8'h6B, 0, 8'h00, 0);
        checkOutput("rearm.gnt0", 32'(gnt0), 1);
        checkOutput("rearm.w_addr", 32'(w_addr), 2);
        applyStimulus(0, 8'h6B, 0, 8'h00, 0);
        checkOutput("rearm.count", 32'(count), 3);

        // Contention, both producers re-armed before every round
        applyReset();
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1, 8'(8'h10 + r), 1, 8'(8'h20 + r), 0);
            winners[r] = gnt0 ? 0 : (gnt1 ? 1 : 2);
            applyStimulus(0, 8'(8'h10 + r), 0, 8'(8'h20 + r), 0);
        end
        for (int r = 0; r < 4; r++)
            checkOutput($sformatf("contend.winner%0d", r), 32'(winners[r]), 32'(expected_winners[r]));
        checkOutput("contend.full", 32'(full), 1);

        // Full: producer 1 blocked until a read frees a slot, then writes at the wrapped address
        applyReset();
        writeWord(8'h11); writeWord(8'h22); writeWord(8'h33); writeWord(8'h44);
        checkOutput("fill.full", 32'(full), 1);
        gcount = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 8'h00, 1, 8'h55, 0);
            if (gnt1) gcount++;
        end
        checkOutput("full.no_gnt1", 32'(gcount), 0);
        applyStimulus(0, 8'h00, 1, 8'h55, 1);
        checkOutput("full.rd_en", 32'(rd_en), 1);
        checkOutput("full.r_addr", 32'(r_addr), 0);
        checkOutput("full.wr_blocked", 32'(wr_en), 0);
        applyStimulus(0, 8'h00, 1, 8'h55, 0);
        checkOutput("full.count_after_rd", 32'(count), 3);
        applyStimulus(0, 8'h00, 1, 8'h55, 0);
        checkOutput("wrap.gnt1", 32'(gnt1), 1);
        checkOutput("wrap.w_addr", 32'(w_addr), 0);
        applyStimulus(0, 8'h00, 0, 8'h55, 0);
        checkOutput("wrap.full", 32'(full), 1);

        // Write and read together on a non-empty FIFO
        applyReset();
        writeWord(8'h77);
        applyStimulus(0, 8'h00, 1, 8'h88, 1);
        checkOutput("both.wr_en", 32'(wr_en), 1);
        checkOutput("both.rd_en", 32'(rd_en), 1);
        applyStimulus(0, 8'h00, 0, 8'h88, 0);
        checkOutput("both.count", 32'(count), 1);

        // Empty read: rd_err one cycle later, nothing consumed
        applyReset();
        applyStimulus(0, 8'h00, 0, 8'h00, 1);
        checkOutput("empty.rd_err", 32'(rd_err), 1);
        checkOutput("empty.rd_en", 32'(rd_en), 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0);
        checkOutput("empty.rd_err_clear", 32'(rd_err), 0);
        checkOutput("empty.count", 32'(count), 0);

        // Empty write and read: write issues, read dropped with rd_err
        applyStimulus(1, 8'h99, 0, 8'h00, 1);
        checkOutput("ewr.gnt0", 32'(gnt0), 1);
        checkOutput("ewr.rd_err", 32'(rd_err), 1);
        checkOutput("ewr.rd_en", 32'(rd_en), 0);
        applyStimulus(0, 8'h99, 0, 8'h00, 0);
        checkOutput("ewr.count", 32'(count), 1);

        // Reset during the ISSUE cycle of a write
        applyReset();
        applyStimulus(1, 8'hC3, 0, 8'h00, 0);
        checkOutput("rst.pre_wr_en", 32'(wr_en), 1);
        #2 n_reset = 1'b0;
        #1;
        checkOutput("rst.wr_en", 32'(wr_en), 0);
        checkOutput("rst.gnt0", 32'(gnt0), 0);
        req0 = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        checkOutput("rst.count", 32'(count), 0);
        checkOutput("rst.empty", 32'(empty), 1);
        checkOutput("rst.w_addr", 32'(w_addr), 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
